// File: rtl/inst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_responder
// Purpose  : Multi-cycle byte-addressed instruction store returning big-endian
//            32-bit words after LATENCY cycles, with a byte-wide load port.
// Revision : 1.0 - initial release
// ============================================================================
module inst_mem_responder #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 1024
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic [31:0] ADDRESS,
  input  logic        LOAD_EN,
  input  logic [9:0]  LOAD_ADDR,
  input  logic [7:0]  LOAD_DATA,
  output logic        BUSYWAIT,
  output logic [31:0] READDATA,
  output logic        VALID,
  output logic        ERROR
);

  localparam int          c_aw       = (DEPTH > 4) ? $clog2(DEPTH) : 3;
  localparam logic [31:0] c_max_addr = 32'(DEPTH - 4);
  localparam logic [3:0]  c_cnt_load = 4'(LATENCY - 1);
  localparam logic [31:0] c_depth    = 32'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READING = 2'd1,
    S_RESP    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_next;
  // Word index of the latched request; legal addresses are always word aligned.
  logic [c_aw-3:0]     r_addr_q;
  logic [c_aw-3:0]     w_addr_next;
  logic [31:0]         r_readdata;
  logic                r_valid;
  logic                r_error;
  logic [7:0]          r_mem [0:DEPTH-1];

  logic                w_illegal;
  logic                w_reject;
  logic                w_finish;
  logic [31:0]         w_word;
  logic [c_aw-1:0]     w_idx0;
  logic [c_aw-1:0]     w_idx1;
  logic [c_aw-1:0]     w_idx2;
  logic [c_aw-1:0]     w_idx3;
  logic [c_aw-1:0]     w_load_idx;
  logic                w_load_ok;

  // Full 32-bit compare: anything past the last whole word is rejected, no wrap.
  assign w_illegal = (ADDRESS[1:0] != 2'b00) || (ADDRESS > c_max_addr);
  assign w_reject  = (r_state == S_IDLE) && READ && w_illegal;

  assign w_idx0 = {r_addr_q, 2'b00};
  assign w_idx1 = {r_addr_q, 2'b01};
  assign w_idx2 = {r_addr_q, 2'b10};
  assign w_idx3 = {r_addr_q, 2'b11};
  assign w_word = {r_mem[w_idx0], r_mem[w_idx1], r_mem[w_idx2], r_mem[w_idx3]};

  assign w_load_idx = c_aw'(LOAD_ADDR);
  assign w_load_ok  = ({22'd0, LOAD_ADDR} < c_depth);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_addr_next  = r_addr_q;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (READ) begin
          w_addr_next = ADDRESS[c_aw-1:2];
          if (w_illegal) begin
            w_state_next = S_RESP;
          end else begin
            w_state_next = S_READING;
            w_cnt_next   = c_cnt_load;
          end
        end
      end
      S_READING: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_RESP;
          w_finish     = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_addr_q   <= '0;
      r_readdata <= 32'd0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_addr_q <= w_addr_next;
      r_valid  <= (w_state_next == S_RESP);
      r_error  <= w_reject;
      if (w_finish) begin
        r_readdata <= w_word;
      end else if (w_reject) begin
        r_readdata <= 32'd0;
      end
    end
  end

  // Store is never cleared; a write on the finishing edge is not seen by that read.
  always_ff @(posedge CLK) begin
    if (LOAD_EN && w_load_ok) begin
      r_mem[w_load_idx] <= LOAD_DATA;
    end
  end

  assign BUSYWAIT = ((r_state == S_IDLE) && READ) || (r_state == S_READING);
  assign READDATA = r_readdata;
  assign VALID    = r_valid;
  assign ERROR    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_mem_responder
// Purpose  : Directed bench for inst_mem_responder (LATENCY=4 and LATENCY=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_mem_responder;

  logic        clk;
  logic        rst;
  logic        read;
  logic        read2;
  logic [31:0] address;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [7:0]  load_data;
  logic        busywait;
  logic [31:0] readdata;
  logic        valid;
  logic        error;
  logic        busy2;
  logic [31:0] readdata2;
  logic        valid2;
  logic        error2;

  int checks = 0;
  int errors = 0;

  inst_mem_responder #(.LATENCY(4), .DEPTH(1024)) dut (
    .CLK(clk), .RESET(rst), .READ(read), .ADDRESS(address),
    .LOAD_EN(load_en), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data),
    .BUSYWAIT(busywait), .READDATA(readdata), .VALID(valid), .ERROR(error)
  );

  inst_mem_responder #(.LATENCY(1), .DEPTH(1024)) dut_min (
    .CLK(clk), .RESET(rst), .READ(read2), .ADDRESS(address),
    .LOAD_EN(load_en), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data),
    .BUSYWAIT(busy2), .READDATA(readdata2), .VALID(valid2), .ERROR(error2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [9:0] a, input logic [7:0] d);
    load_addr = a;
    load_data = d;
    load_en   = 1'b1;
    step();
    load_en   = 1'b0;
  endtask

  task automatic load_word(input logic [9:0] a, input logic [31:0] w);
    load_byte(a,         w[31:24]);
    load_byte(a + 10'd1, w[23:16]);
    load_byte(a + 10'd2, w[15:8]);
    load_byte(a + 10'd3, w[7:0]);
  endtask

  // Full fetch on the LATENCY=4 instance, from request cycle through return to IDLE.
  task automatic do_fetch(input string tag, input logic [31:0] a,
                          input logic [31:0] exp, input logic err);
    address = a;
    read    = 1'b1;
    #1;
    check({tag, "_busy_req"}, 32'(busywait), 32'd1);
    if (!err) begin
      for (int i = 0; i < 4; i++) begin
        step();
        check({tag, "_busy_rd"}, 32'(busywait), 32'd1);
        check({tag, "_valid_rd"}, 32'(valid), 32'd0);
      end
    end
    step();
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_error"}, 32'(error), 32'(err));
    check({tag, "_data"}, readdata, exp);
    check({tag, "_busy_resp"}, 32'(busywait), 32'd0);
    read = 1'b0;
    step();
    check({tag, "_valid_after"}, 32'(valid), 32'd0);
    check({tag, "_busy_after"}, 32'(busywait), 32'd0);
  endtask

  initial begin
    int t;
    int last;
    int k;
    logic [31:0] pipe_exp [3];

    rst = 1'b1; read = 1'b0; read2 = 1'b0; address = 32'd0;
    load_en = 1'b0; load_addr = 10'd0; load_data = 8'd0;
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_data", readdata, 32'd0);
    check("rst_busy", 32'(busywait), 32'd0);
    check("rst_valid_min", 32'(valid2), 32'd0);
    read = 1'b1;
    #1;
    check("rst_busy_follows_read", 32'(busywait), 32'd1);
    step();
    check("rst_no_valid", 32'(valid), 32'd0);
    read = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Basic fetch
    load_word(10'd0, 32'h0001000C);
    do_fetch("basic", 32'd0, 32'h0001000C, 1'b0);

    // Illegal and boundary addresses
    do_fetch("misaligned", 32'd6, 32'd0, 1'b1);
    do_fetch("past_end", 32'd1024, 32'd0, 1'b1);
    do_fetch("high_bits", 32'hFFFF_FFFC, 32'd0, 1'b1);
    load_word(10'd1020, 32'hDEADBEEF);
    do_fetch("last_word", 32'd1020, 32'hDEADBEEF, 1'b0);

    // Back-to-back fetches with READ held high
    load_word(10'd4, 32'h00020004);
    load_word(10'd8, 32'h02030102);
    pipe_exp[0] = 32'h0001000C;
    pipe_exp[1] = 32'h00020004;
    pipe_exp[2] = 32'h02030102;
    address = 32'd0;
    read    = 1'b1;
    t = 0; last = 0; k = 0;
    while (k < 3 && t < 60) begin
      step();
      t++;
      if (valid) begin
        check("pipe_data", readdata, pipe_exp[k]);
        check("pipe_error", 32'(error), 32'd0);
        if (k > 0) check("pipe_gap", 32'(t - last), 32'd6);
        last = t;
        k++;
        address = 32'(4 * k);
      end
    end
    check("pipe_count", 32'(k), 32'd3);
    read = 1'b0;
    step();
    step();

    // Address change and early load while a fetch is in flight
    address = 32'd4;
    read    = 1'b1;
    step();
    address = 32'd8;
    step();
    load_addr = 10'd7; load_data = 8'hAA; load_en = 1'b1;
    step();
    load_en = 1'b0;
    step();
    check("midload_valid_early", 32'(valid), 32'd0);
    step();
    check("midload_valid", 32'(valid), 32'd1);
    check("midload_data", readdata, 32'h000200AA);
    read = 1'b0;
    step();

    // Load landing on the finishing edge is not seen by that fetch
    address = 32'd8;
    read    = 1'b1;
    step(); step(); step(); step();
    load_addr = 10'd11; load_data = 8'h55; load_en = 1'b1;
    step();
    load_en = 1'b0;
    check("lateload_valid", 32'(valid), 32'd1);
    check("lateload_data", readdata, 32'h02030102);
    read = 1'b0;
    step();
    do_fetch("lateload_after", 32'd8, 32'h02030155, 1'b0);

    // Reset two cycles into READING
    address = 32'd0;
    read    = 1'b1;
    step(); step(); step();
    rst  = 1'b1;
    read = 1'b0;
    #1;
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_data", readdata, 32'd0);
    check("midrst_busy", 32'(busywait), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("midrst_no_valid", 32'(valid), 32'd0);
    end
    do_fetch("post_rst", 32'd0, 32'h0001000C, 1'b0);

    // LATENCY=1 instance
    address = 32'd0;
    read2   = 1'b1;
    #1;
    check("min_busy_req", 32'(busy2), 32'd1);
    step();
    check("min_busy_rd", 32'(busy2), 32'd1);
    check("min_valid_rd", 32'(valid2), 32'd0);
    step();
    check("min_valid", 32'(valid2), 32'd1);
    check("min_error", 32'(error2), 32'd0);
    check("min_data", readdata2, 32'h0001000C);
    check("min_busy_resp", 32'(busy2), 32'd0);
    read2 = 1'b0;
    step();
    check("min_valid_after", 32'(valid2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
